// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared mode encodings and width helpers for the DDR capture packer
package ddr_pkg;

  localparam logic DDR_MODE = 1'b1;
  localparam logic SDR_MODE = 1'b0;

  // A gathered beat is one sample from each half of the clock.
  function automatic int beat_w(input int n);
    return 2 * n;
  endfunction

  // Packer slot counter width.
  function automatic int cnt_w(input int pack);
    return $clog2(pack);
  endfunction

endpackage

// File: rtl/ddr_edge_gather.sv
// rtl/ddr_edge_gather.sv - dual-edge capture, fall retiming and SDR/DDR beat gathering
module ddr_edge_gather
  import ddr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ddr_mode,
  input  logic [N-1:0]         d_in,
  output logic [N-1:0]         q_rise,
  output logic [N-1:0]         q_fall,
  output logic                 mode_chg,
  output logic [beat_w(N)-1:0] beat,
  output logic                 beat_valid
);

  localparam int BW = beat_w(N);

  logic [N-1:0]  q_rise_q, q_rise_d;
  logic [N-1:0]  q_fall_q, q_fall_d;
  logic [N-1:0]  low_q, low_d;
  logic          en_r_q, en_r_d;
  logic          mode_r_q, mode_r_d;
  logic          phase_q, phase_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] beat_q, beat_d;

  // Mode change is seen at the rising edge that loads the new mode_r.
  assign mode_chg = (ddr_mode != mode_r_q);

  // Next-state: rise capture, and gather of the sample held since the previous rising edge.
  always_comb begin
    q_rise_d = d_in;
    q_fall_d = d_in;
    en_r_d   = en;
    mode_r_d = ddr_mode;
    low_d    = low_q;
    phase_d  = phase_q;
    beat_d   = beat_q;
    valid_d  = 1'b0;
    if (mode_chg) begin
      phase_d = 1'b0;
    end else if (mode_r_q == DDR_MODE) begin
      if (en_r_q) begin
        beat_d  = {q_fall_q, q_rise_q};
        valid_d = 1'b1;
      end
    end else if (en_r_q) begin
      if (!phase_q) begin
        low_d   = q_rise_q;
        phase_d = 1'b1;
      end else begin
        beat_d  = {q_rise_q, low_q};
        valid_d = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  // Rising-edge registers: raw capture, qualifier, mode and gather stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rise_q <= '0;
      en_r_q   <= 1'b0;
      mode_r_q <= 1'b0;
      low_q    <= '0;
      phase_q  <= 1'b0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      q_rise_q <= q_rise_d;
      en_r_q   <= en_r_d;
      mode_r_q <= mode_r_d;
      low_q    <= low_d;
      phase_q  <= phase_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
    end
  end

  // Falling-edge capture; consumed by the following rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_fall_q <= '0;
    end else begin
      q_fall_q <= q_fall_d;
    end
  end

  assign q_rise     = q_rise_q;
  assign q_fall     = q_fall_q;
  assign beat       = beat_q;
  assign beat_valid = valid_q;

endmodule

// File: rtl/ddr_capture_pack.sv
// rtl/ddr_capture_pack.sv - dual-edge capture with beat pipeline and wide-word packer
module ddr_capture_pack
  import ddr_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DEPTH = 2,
  parameter  int PACK  = 2,
  localparam int CW    = cnt_w(PACK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ddr_mode,
  input  logic [N-1:0]          d_in,
  output logic [N-1:0]          q_rise,
  output logic [N-1:0]          q_fall,
  output logic [2*N-1:0]        beat_out,
  output logic                  beat_valid,
  output logic [2*N*PACK-1:0]   word_out,
  output logic                  word_valid,
  output logic [CW-1:0]         beat_cnt
);

  localparam int BW = beat_w(N);
  localparam int WW = BW * PACK;

  logic [BW-1:0] g_beat;
  logic          g_valid;
  logic          mode_chg;
  logic [BW-1:0] pipe_beat;
  logic          pipe_valid;

  ddr_edge_gather #(.N(N)) u_gather (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ddr_mode   (ddr_mode),
    .d_in       (d_in),
    .q_rise     (q_rise),
    .q_fall     (q_fall),
    .mode_chg   (mode_chg),
    .beat       (g_beat),
    .beat_valid (g_valid)
  );

  if (DEPTH > 1) begin : g_pipe
    logic [BW-1:0]    data_q [DEPTH-1];
    logic [BW-1:0]    data_d [DEPTH-1];
    logic [DEPTH-2:0] vld_q, vld_d;

    // Shift beats down the pipe; a mode change flushes every valid bit.
    always_comb begin
      data_d[0] = g_beat;
      vld_d[0]  = g_valid;
      for (int i = 1; i < DEPTH - 1; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      if (mode_chg) vld_d = '0;
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH - 1; i++) data_q[i] <= '0;
        vld_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) data_q[i] <= data_d[i];
        vld_q <= vld_d;
      end
    end

    assign pipe_beat  = data_q[DEPTH-2];
    assign pipe_valid = vld_q[DEPTH-2];
  end else begin : g_nopipe
    assign pipe_beat  = g_beat;
    assign pipe_valid = g_valid;
  end

  assign beat_out   = pipe_beat;
  assign beat_valid = pipe_valid;

  logic [BW-1:0] slot_q [PACK-1];
  logic [BW-1:0] slot_d [PACK-1];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic          wv_q, wv_d;

  // Packer: park beats in slots, emit the word on the last beat; mode change drops a partial word.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (mode_chg) begin
      cnt_d = '0;
    end else if (pipe_valid) begin
      if (cnt_q == CW'(PACK - 1)) begin
        for (int i = 0; i < PACK - 1; i++) word_d[i*BW +: BW] = slot_q[i];
        word_d[(PACK-1)*BW +: BW] = pipe_beat;
        wv_d  = 1'b1;
        cnt_d = '0;
      end else begin
        for (int i = 0; i < PACK - 1; i++) begin
          if (cnt_q == CW'(i)) slot_d[i] = pipe_beat;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PACK - 1; i++) slot_q[i] <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      for (int i = 0; i < PACK - 1; i++) slot_q[i] <= slot_d[i];
      cnt_q  <= cnt_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_ddr_capture_pack.sv
// tb/tb_ddr_capture_pack.sv - randomized and directed bench with a stream-level reference model
module tb_ddr_capture_pack;

  localparam int N     = 8;
  localparam int DEPTH = 2;
  localparam int PACK  = 2;
  localparam int BW    = 2 * N;
  localparam int WW    = BW * PACK;
  localparam int MAXC  = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ddr_mode = 1'b0;
  logic [N-1:0]  d_in = '0;
  logic [N-1:0]  q_rise, q_fall;
  logic [BW-1:0] beat_out;
  logic          beat_valid;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic [0:0]    beat_cnt;

  ddr_capture_pack #(.N(N), .DEPTH(DEPTH), .PACK(PACK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ddr_mode   (ddr_mode),
    .d_in       (d_in),
    .q_rise     (q_rise),
    .q_fall     (q_fall),
    .beat_out   (beat_out),
    .beat_valid (beat_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: beats are scheduled by the sample edge that produced them.
  int            t = 0;
  bit            exp_valid [MAXC];
  logic [BW-1:0] exp_beat  [MAXC];
  logic [BW-1:0] pq[$];
  logic [WW-1:0] exp_word;
  bit            exp_wv;
  bit            mode_prev;
  bit            phase;
  logic [N-1:0]  low;

  task automatic model_reset();
    for (int k = 0; k < MAXC; k++) begin
      exp_valid[k] = 1'b0;
      exp_beat[k]  = '0;
    end
    pq.delete();
    exp_word  = '0;
    exp_wv    = 1'b0;
    mode_prev = 1'b0;
    phase     = 1'b0;
    low       = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] f, input bit e, input bit m);
    bit chg;
    t++;
    chg       = (m != mode_prev);
    mode_prev = m;
    exp_wv    = 1'b0;
    if (chg) begin
      pq.delete();
      for (int k = t; k < t + DEPTH; k++) exp_valid[k] = 1'b0;
      phase = 1'b0;
    end else if (exp_valid[t-1]) begin
      pq.push_back(exp_beat[t-1]);
      if (pq.size() == PACK) begin
        for (int i = 0; i < PACK; i++) exp_word[i*BW +: BW] = pq[i];
        exp_wv = 1'b1;
        pq.delete();
      end
    end
    if (e) begin
      if (m) begin
        exp_valid[t+DEPTH] = 1'b1;
        exp_beat[t+DEPTH]  = {f, r};
      end else if (!phase) begin
        low   = r;
        phase = 1'b1;
      end else begin
        exp_valid[t+DEPTH] = 1'b1;
        exp_beat[t+DEPTH]  = {r, low};
        phase = 1'b0;
      end
    end
  endtask

  // One clock: rise value before posedge, fall value before negedge; called at negedge+1.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] f, input bit e, input bit m);
    d_in = r; en = e; ddr_mode = m;
    @(posedge clk);
    model_edge(r, f, e, m);
    #1;
    chk("q_rise", q_rise, r);
    chk("beat_valid", beat_valid, exp_valid[t]);
    if (exp_valid[t]) chk("beat_out", beat_out, exp_beat[t]);
    chk("word_valid", word_valid, exp_wv);
    chk("word_out", word_out, exp_word);
    chk("beat_cnt", beat_cnt, pq.size());
    d_in = f;
    @(negedge clk);
    #1;
    chk("q_fall", q_fall, f);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_q_rise"}, q_rise, 0);
    chk({tag, "_q_fall"}, q_fall, 0);
    chk({tag, "_beat_valid"}, beat_valid, 0);
    chk({tag, "_beat_out"}, beat_out, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_word_out"}, word_out, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0; d_in = 8'hFF; en = 1'b1; ddr_mode = 1'b1;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    #1;
    check_zero("rst_neg");
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    hold_reset(2);
  endtask

  bit m;

  initial begin
    model_reset();
    hold_reset(3);

    // DDR stream 0x11/0x22 then 0x33/0x44
    step(8'h00, 8'h00, 0, 1); step(8'h00, 8'h00, 0, 1);
    step(8'h11, 8'h22, 1, 1); step(8'h33, 8'h44, 1, 1);
    step(8'h00, 8'h00, 0, 1);
    chk("ddr_beat0", beat_out, 16'h2211);
    step(8'h00, 8'h00, 0, 1);
    chk("ddr_beat1", beat_out, 16'h4433);
    step(8'h00, 8'h00, 0, 1);
    chk("ddr_word_valid", word_valid, 1);
    chk("ddr_word", word_out, 32'h44332211);

    // en gap between two beats
    step(8'h01, 8'h02, 1, 1); step(8'hEE, 8'hEE, 0, 1); step(8'h03, 8'h04, 1, 1);
    step(8'h00, 8'h00, 0, 1); step(8'h00, 8'h00, 0, 1);
    chk("gap_cnt_hold", beat_cnt, 1);
    step(8'h00, 8'h00, 0, 1);
    chk("gap_word", word_out, 32'h04030201);

    // SDR: falls carry 0x5A and must never appear
    step(8'h00, 8'h00, 0, 0); step(8'h00, 8'h00, 0, 0);
    step(8'hA1, 8'h5A, 1, 0); step(8'hA2, 8'h5A, 1, 0);
    step(8'hA3, 8'h5A, 1, 0); step(8'hA4, 8'h5A, 1, 0);
    step(8'h00, 8'h5A, 0, 0); step(8'h00, 8'h5A, 0, 0); step(8'h00, 8'h5A, 0, 0);
    chk("sdr_word", word_out, 32'hA4A3A2A1);

    // Mode switch with one beat parked in the packer
    step(8'h00, 8'h00, 0, 1); step(8'h00, 8'h00, 0, 1);
    step(8'h55, 8'h66, 1, 1); step(8'h77, 8'h88, 1, 1);
    step(8'h00, 8'h00, 0, 1); step(8'h00, 8'h00, 0, 1);
    chk("sw_cnt_before", beat_cnt, 1);
    step(8'h00, 8'h00, 0, 0);
    chk("sw_cnt_cleared", beat_cnt, 0);
    chk("sw_no_word", word_valid, 0);
    chk("sw_beat_dropped", beat_valid, 0);
    step(8'hB1, 8'h00, 1, 0); step(8'hB2, 8'h00, 1, 0);
    step(8'hB3, 8'h00, 1, 0); step(8'hB4, 8'h00, 1, 0);
    step(8'h00, 8'h00, 0, 0); step(8'h00, 8'h00, 0, 0); step(8'h00, 8'h00, 0, 0);
    chk("sw_new_word", word_out, 32'hB4B3B2B1);

    // Async reset mid DDR burst, then latency after release
    for (int i = 0; i < 5; i++) step(8'($urandom), 8'($urandom), 1, 1);
    async_reset();
    for (int i = 0; i < 6; i++) step(8'($urandom), 8'($urandom), 1, 1);

    // Random traffic with occasional mode flips and resets
    m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) m = ~m;
      step(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), m);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_capture_pack.md
Name: ddr_capture_pack

Overview:
Parametrised dual-edge input capture block, successor to our posedge/negedge register pair. It samples d_in on both clock edges, retimes the falling-edge sample into the posedge domain, and assembles a 2N-bit beat per cycle. The beat passes through a configurable pipeline, then a packer gathers PACK beats into one wide word. An SDR mode uses rising edges only. Sits between a source-synchronous pad interface and posedge-only datapath logic.

Parameters:
N, 8, data input width per edge
DEPTH, 2, beat pipeline stages including the gather register (legal >= 1)
PACK, 2, beats per packed word (legal >= 2)
CW, $clog2(PACK), packer count width (localparam)

Ports:
clk  input  1  single clock; data sampled on both edges
rst_n  input  1  asynchronous active-low reset
en  input  1  sample qualifier, captured at the rising edge together with d_in
ddr_mode  input  1  1 = DDR (rise+fall), 0 = SDR (rising edges only)
d_in  input  N  data
q_rise  output  N  raw rising-edge capture
q_fall  output  N  raw falling-edge capture
beat_out  output  2N  pipelined beat; low half = earlier sample
beat_valid  output  1  beat_out qualifier
word_out  output  2N*PACK  packed word; beat 0 in LSBs
word_valid  output  1  one-cycle pulse per completed word
beat_cnt  output  CW  beats held in the packer

Behaviour:
- Reset: every output and internal register is 0, including the negedge register. Reset acts immediately and is independent of clk. After release, nothing is valid until a rising edge samples en=1.
- Capture: q_rise and en_r update on posedge. q_fall updates on negedge. There is no combinational clk mux on any output.
- DDR gather at posedge T+1, for the rise sample taken at posedge T:
  - beat = {q_fall, q_rise}; q_fall is the negedge between T and T+1.
  - Valid when en_r = 1.
- SDR gather:
  - Rising samples with en=1 alternate into low half then high half, tracked by a phase bit.
  - The gather is valid only when the high half is written.
  - q_fall is still captured but is ignored.
  - en=0 holds the phase.
- Pipeline: DEPTH-1 further posedge stages carry data and valid. Latency from rise sample edge T to beat_out: DEPTH cycles in DDR. In SDR, DEPTH cycles after the second sample.
- Packer:
  - Each beat_valid beat is written into slot beat_cnt, then beat_cnt increments.
  - On the PACK-th beat: word_out updates at the next posedge, word_valid pulses for one cycle, and beat_cnt wraps to 0.
  - word_out holds its value between words.
  - Back-to-back beats are sustained without loss. Throughput is one word per PACK cycles in DDR.
- ddr_mode is registered as mode_r. A change of mode_r:
  - clears the SDR phase;
  - clears all pipeline valid bits, so in-flight beats are dropped;
  - clears beat_cnt, discarding any partial word; no word_valid is produced.
  - New-mode beats start on the next qualifying edge.
- en=0 slots create gaps only. The packer count and partial data are held.
- beat_out data is don't-care when beat_valid=0. word_out is stable except at the word_valid update.
- Async reset mid-word discards everything.

Decomposition:
- Shared package ddr_pkg: mode encodings (DDR_MODE=1, SDR_MODE=0), the beat width function 2*N, and the CW computation.
- One natural sub-module, ddr_edge_gather: both-edge capture, fall retiming, SDR phase, and gathered beat + valid.
- The pipeline and packer stay in the top module.

Test Plan:
All cases use N=8, DEPTH=2, PACK=2.
- Reset: hold rst_n=0 with clk toggling and d_in=0xFF -> all outputs 0. Assert rst_n mid-cycle -> outputs clear without a clock edge.
- DDR stream: en=1, rise/fall = 0x11/0x22 then 0x33/0x44 from edge T0 -> beat_out 0x2211 valid at T0+2, 0x4433 at T0+3. word_out 0x44332211 with word_valid pulsed at T0+4.
- SDR: ddr_mode=0, rises 0xA1,0xA2,0xA3,0xA4, falls 0x5A -> beats 0xA2A1 and 0xA4A3, valid on alternate cycles. word_out 0xA4A3A2A1. No 0x5A appears.
- en gap: DDR, en=0 on one rise between two valid beats -> one-cycle beat_valid gap. beat_cnt holds at 1. Word completes on the next beat with correct order.
- Mode switch mid-word: one beat packed (beat_cnt=1), then toggle ddr_mode -> beat_cnt=0, no word_valid, in-flight beats dropped. The next word is built only from new-mode beats.
- Async reset mid-stream: assert rst_n between edges during a DDR burst -> immediate clear. After release, no beat_valid until DEPTH cycles after the first en=1 rise.
